// File: rtl/uart_tx_arbiter_if.sv
// Requester/FIFO-push bundle for the UART TX arbiter.
// The slave side is the arbiter; the master side is the requesters plus the FIFO.
interface uart_tx_arbiter_if #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            src_last;
  logic [NUM_SRC-1:0]            src_ready;
  logic                          fifo_full;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [NUM_SRC-1:0]            grant;
  logic                          busy;
  logic                          timeout_err;

  modport master (
    output src_valid, src_data, src_last, fifo_full,
    input  src_ready, wr_en, wr_data, grant, busy, timeout_err
  );

  modport slave (
    input  src_valid, src_data, src_last, fifo_full,
    output src_ready, wr_en, wr_data, grant, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares one UART TX FIFO push port
// among NUM_SRC byte streams, with an idle timeout that releases stalled packets.

module uart_tx_arb_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sel,
  input  logic                  fifo_full,
  input  logic                  valid,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  push,
  output logic                  push_last,
  output logic [DATA_WIDTH-1:0] data_m
);
  assign ready     = sel & ~fifo_full;
  assign push      = ready & valid;
  assign push_last = push & last;
  // Data is masked so the lanes can be OR-combined; also forces wr_data=0 off-push.
  assign data_m    = push ? data : '0;
endmodule

module uart_tx_arbiter #(
  parameter int NUM_SRC     = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SRC - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                              state, state_n;
  logic [NUM_SRC-1:0]                  grant_q, grant_n;
  logic [IDX_W-1:0]                    gidx, gidx_n, gnext;
  logic [IDX_W-1:0]                    rr_ptr, rr_n;
  logic [IDX_W-1:0]                    pick;
  logic                                pick_vld;
  logic [CNT_W-1:0]                    idle_cnt, cnt_n;
  logic                                terr_q, terr_n;

  logic [NUM_SRC-1:0]                  sel, ready, push, push_last;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  data_m;
  logic [DATA_WIDTH-1:0]               wd;
  logic                                accept, accept_last, gvalid;

  assign sel = (state == LOCK) ? grant_q : '0;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    uart_tx_arb_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .sel       (sel[i]),
      .fifo_full (bus.fifo_full),
      .valid     (bus.src_valid[i]),
      .last      (bus.src_last[i]),
      .data      (bus.src_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .ready     (ready[i]),
      .push      (push[i]),
      .push_last (push_last[i]),
      .data_m    (data_m[i])
    );
  end

  always_comb begin
    wd = '0;
    for (int i = 0; i < NUM_SRC; i++) wd = wd | data_m[i];
  end

  assign accept      = |push;
  assign accept_last = |push_last;
  assign gvalid      = bus.src_valid[gidx];
  assign gnext       = (gidx == IDX_LAST) ? '0 : gidx + IDX_W'(1);

  assign bus.src_ready   = ready;
  assign bus.wr_en       = accept;
  assign bus.wr_data     = wd;
  assign bus.grant       = grant_q;
  assign bus.busy        = (state == LOCK);
  assign bus.timeout_err = terr_q;

  // Scan descending so the lowest offset from rr_ptr is the final (winning) write.
  always_comb begin
    int idx;
    logic [IDX_W-1:0] cand;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      cand = IDX_W'(idx);
      if (bus.src_valid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant_q;
    gidx_n  = gidx;
    rr_n    = rr_ptr;
    cnt_n   = idle_cnt;
    terr_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (pick_vld) begin
          state_n = LOCK;
          gidx_n  = pick;
          grant_n = NUM_SRC'(1) << pick;
        end
      end
      LOCK: begin
        if (accept) begin
          cnt_n = '0;
          if (accept_last) begin
            state_n = IDLE;
            grant_n = '0;
            rr_n    = gnext;
          end
        end else if (!gvalid) begin
          if (idle_cnt >= CNT_LIM) begin
            state_n = IDLE;
            grant_n = '0;
            rr_n    = gnext;
            terr_n  = 1'b1;
          end else if (idle_cnt != CNT_MAX) begin
            cnt_n = idle_cnt + CNT_W'(1);
          end
        end
        // valid held under fifo_full is backpressure: counter holds
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      grant_q  <= '0;
      gidx     <= '0;
      rr_ptr   <= '0;
      idle_cnt <= '0;
      terr_q   <= 1'b0;
    end else begin
      state    <= state_n;
      grant_q  <= grant_n;
      gidx     <= gidx_n;
      rr_ptr   <= rr_n;
      idle_cnt <= cnt_n;
      terr_q   <= terr_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed-vector bench for uart_tx_arbiter (2 sources, 8-bit, TIMEOUT_CYC=8).
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic reset;

  uart_tx_arbiter_if #(.NUM_SRC(2), .DATA_WIDTH(8)) bus ();

  uart_tx_arbiter #(.NUM_SRC(2), .DATA_WIDTH(8), .TIMEOUT_CYC(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] v;
    logic [7:0] d0, d1;
    logic [1:0] l;
    logic       full;
    logic       we;
    logic [7:0] wd;
    logic [1:0] g, r;
    logic       b, t;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(logic rst, logic [1:0] v, logic [7:0] d0, logic [7:0] d1,
                              logic [1:0] l, logic full, logic we, logic [7:0] wd,
                              logic [1:0] g, logic [1:0] r, logic b, logic t);
    vec_t x;
    x.rst = rst; x.v = v; x.d0 = d0; x.d1 = d1; x.l = l; x.full = full;
    x.we = we; x.wd = wd; x.g = g; x.r = r; x.b = b; x.t = t;
    return x;
  endfunction

  task automatic drive(logic rst, logic [1:0] v, logic [7:0] d0, logic [7:0] d1,
                       logic [1:0] l, logic full);
    reset         = rst;
    bus.src_valid = v;
    bus.src_data  = {d1, d0};
    bus.src_last  = l;
    bus.fifo_full = full;
  endtask

  initial begin
    int cnt0, cnt1;
    logic [1:0] exp_g;
    logic [7:0] exp_d;

    // reset / contention
    tbl.push_back(mk(0, 2'b11, 8'hA0, 8'hB0, 2'b00, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 8'hA0, 8'hB0, 2'b00, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b00, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b00, 0, 1, 8'hA0, 2'b01, 2'b01, 1, 0));
    tbl.push_back(mk(1, 2'b11, 8'hA1, 8'hB0, 2'b00, 0, 1, 8'hA1, 2'b01, 2'b01, 1, 0));
    tbl.push_back(mk(1, 2'b11, 8'hA2, 8'hB0, 2'b01, 0, 1, 8'hA2, 2'b01, 2'b01, 1, 0));
    tbl.push_back(mk(1, 2'b11, 8'hA3, 8'hB0, 2'b00, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 2'b11, 8'hA3, 8'hB0, 2'b00, 0, 1, 8'hB0, 2'b10, 2'b10, 1, 0));
    tbl.push_back(mk(1, 2'b11, 8'hA3, 8'hB1, 2'b00, 0, 1, 8'hB1, 2'b10, 2'b10, 1, 0));
    tbl.push_back(mk(1, 2'b11, 8'hA3, 8'hB2, 2'b10, 0, 1, 8'hB2, 2'b10, 2'b10, 1, 0));
    tbl.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0));
    // backpressure: 5 full cycles mid-packet
    tbl.push_back(mk(1, 2'b01, 8'hC0, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 2'b01, 8'hC0, 8'h00, 2'b00, 0, 1, 8'hC0, 2'b01, 2'b01, 1, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 2'b01, 8'hC1, 8'h00, 2'b00, 1, 0, 8'h00, 2'b01, 2'b00, 1, 0));
    tbl.push_back(mk(1, 2'b01, 8'hC1, 8'h00, 2'b00, 0, 1, 8'hC1, 2'b01, 2'b01, 1, 0));
    tbl.push_back(mk(1, 2'b01, 8'hC2, 8'h00, 2'b01, 0, 1, 8'hC2, 2'b01, 2'b01, 1, 0));
    tbl.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0));
    // timeout: one byte, then 8 idle cycles while src1 waits
    tbl.push_back(mk(1, 2'b01, 8'hD0, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 2'b01, 8'hD0, 8'h00, 2'b00, 0, 1, 8'hD0, 2'b01, 2'b01, 1, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 2'b10, 8'h00, 8'hE0, 2'b00, 0, 0, 8'h00, 2'b01, 2'b01, 1, 0));
    tbl.push_back(mk(1, 2'b10, 8'h00, 8'hE0, 2'b10, 0, 0, 8'h00, 2'b00, 2'b00, 0, 1));
    tbl.push_back(mk(1, 2'b10, 8'h00, 8'hE0, 2'b10, 0, 1, 8'hE0, 2'b10, 2'b10, 1, 0));
    tbl.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0));
    // move rr_ptr to 1, lock src1, reset mid-packet, src0 must win the tie
    tbl.push_back(mk(1, 2'b01, 8'h90, 8'h00, 2'b01, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 2'b01, 8'h90, 8'h00, 2'b01, 0, 1, 8'h90, 2'b01, 2'b01, 1, 0));
    tbl.push_back(mk(1, 2'b11, 8'hF0, 8'h5A, 2'b00, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 2'b11, 8'hF0, 8'h5A, 2'b00, 0, 1, 8'h5A, 2'b10, 2'b10, 1, 0));
    tbl.push_back(mk(1, 2'b11, 8'hF0, 8'h5B, 2'b00, 0, 1, 8'h5B, 2'b10, 2'b10, 1, 0));
    tbl.push_back(mk(0, 2'b11, 8'hF0, 8'h5C, 2'b00, 0, 1, 8'h5C, 2'b10, 2'b10, 1, 0));
    tbl.push_back(mk(1, 2'b11, 8'hF0, 8'h5C, 2'b00, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 2'b11, 8'hF0, 8'h5C, 2'b00, 0, 1, 8'hF0, 2'b01, 2'b01, 1, 0));
    tbl.push_back(mk(1, 2'b11, 8'hF1, 8'h5C, 2'b01, 0, 1, 8'hF1, 2'b01, 2'b01, 1, 0));
    tbl.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0));

    drive(0, 2'b11, 8'hA0, 8'hB0, 2'b00, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].l, tbl[i].full);
      #1;
      nvec++;
      if ({bus.wr_en, bus.wr_data, bus.grant, bus.src_ready, bus.busy, bus.timeout_err} !==
          {tbl[i].we, tbl[i].wd, tbl[i].g, tbl[i].r, tbl[i].b, tbl[i].t}) begin
        nerr++;
        $display("FAIL vec%0d: got we=%b wd=%h g=%b rdy=%b busy=%b terr=%b, want we=%b wd=%h g=%b rdy=%b busy=%b terr=%b",
                 i, bus.wr_en, bus.wr_data, bus.grant, bus.src_ready, bus.busy, bus.timeout_err,
                 tbl[i].we, tbl[i].wd, tbl[i].g, tbl[i].r, tbl[i].b, tbl[i].t);
      end
    end

    // fairness: both sources stream 1-byte packets; rr_ptr is 1 here
    cnt0 = 0; cnt1 = 0; exp_g = 2'b10;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      drive(1, 2'b11, 8'h10 + 8'(k), 8'h20 + 8'(k), 2'b11, 0);
      #1;
      nvec++;
      exp_d = (exp_g == 2'b01) ? 8'h10 + 8'(k) : 8'h20 + 8'(k);
      if (k % 2 == 0) begin
        if (bus.wr_en !== 1'b0 || bus.grant !== 2'b00) begin
          nerr++;
          $display("FAIL rr_idle%0d: got we=%b g=%b, want we=0 g=00", k, bus.wr_en, bus.grant);
        end
      end else begin
        if (bus.wr_en !== 1'b1 || bus.grant !== exp_g || bus.wr_data !== exp_d) begin
          nerr++;
          $display("FAIL rr_push%0d: got we=%b g=%b wd=%h, want we=1 g=%b wd=%h",
                   k, bus.wr_en, bus.grant, bus.wr_data, exp_g, exp_d);
        end
        if (bus.wr_en === 1'b1 && bus.grant === 2'b01) cnt0++;
        if (bus.wr_en === 1'b1 && bus.grant === 2'b10) cnt1++;
        exp_g = ~exp_g;
      end
    end
    nvec++;
    if (cnt0 != 10 || cnt1 != 10) begin
      nerr++;
      $display("FAIL rr_share: got src0=%0d src1=%0d pushes, want 10 and 10", cnt0, cnt1);
    end

    @(negedge clk);
    drive(1, 2'b00, 8'h00, 8'h00, 2'b00, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
